// File: rtl/rf_arb_pkg.sv
// Shared defaults, id-width helper and FSM state type for the register-file read arbiter.
// The optional RF_XZR_EN define (used by rf_read_arbiter) makes register 31 read as zero.
package rf_arb_pkg;
  localparam int DEF_NREQ   = 4;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 64;

  // Requester index width; a single requester still needs one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W = id_w(DEF_NREQ);

  typedef enum logic [1:0] {IDLE, READ, WAIT} arb_state_e;
endpackage

// File: rtl/rf_read_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted req scanning upward from ptr+1, wrapping.
module rr_picker import rf_arb_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = ID_W
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters.
// Define RF_XZR_EN to make register 31 read as zero regardless of mux_data.
module rf_read_arbiter import rf_arb_pkg::*; #(
  parameter int NREQ   = DEF_NREQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0][ADDR_W-1:0] raddr,
  output logic [NREQ-1:0]             gnt,
  output logic [ADDR_W-1:0]           mux_sel,
  input  logic [DATA_W-1:0]           mux_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [id_w(NREQ)-1:0]       rd_id,
  output logic [DATA_W-1:0]           rd_data
);
  // state | meaning
  // IDLE  | nothing latched, waiting for any req
  // READ  | gnt pulse to winner, mux_sel driven, rd_data captured at cycle end
  // WAIT  | result presented on rd_valid until rd_ready
  localparam int IW = id_w(NREQ);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       win_q, win_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [ADDR_W-1:0]   mux_sel_q, mux_sel_d;
  logic                rd_valid_q, rd_valid_d;
  logic [IW-1:0]       rd_id_q, rd_id_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] pick_ptr;
  logic          take;
  logic          zero_reg;

  // On acceptance the pointer moves to rd_id in the same cycle, so the picker sees it early.
  assign pick_ptr = (state_q == WAIT) ? rd_id_q : ptr_q;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef RF_XZR_EN
  assign zero_reg = (mux_sel_q == ADDR_W'(31));
`else
  assign zero_reg = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    gnt_d      = '0;
    mux_sel_d  = mux_sel_q;
    rd_valid_d = rd_valid_q;
    rd_id_d    = rd_id_q;
    rd_data_d  = rd_data_q;
    take       = 1'b0;
    case (state_q)
      IDLE: take = pick_found;
      READ: begin
        rd_data_d  = zero_reg ? '0 : mux_data;
        rd_id_d    = win_q;
        rd_valid_d = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (rd_ready) begin
          ptr_d      = rd_id_q;
          rd_valid_d = 1'b0;
          state_d    = IDLE;
          take       = pick_found;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      win_d           = pick_idx;
      mux_sel_d       = raddr[pick_idx];
      gnt_d[pick_idx] = 1'b1;
      state_d         = READ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(NREQ - 1);
      win_q      <= '0;
      gnt_q      <= '0;
      mux_sel_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      mux_sel_q  <= mux_sel_d;
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign gnt      = gnt_q;
  assign mux_sel  = mux_sel_q;
  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign rd_data  = rd_data_q;
endmodule

// File: doc/rf_read_arbiter.md
RF_READ_ARBITER -- requirements
Module: rf_read_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the register-file read port.
REQ-002 Parameter ADDR_W, default 5, register address width (32 registers).
REQ-003 Parameter DATA_W, default 64, register data width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising clock edge.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req  input  NREQ  per-requester read request; held high until the matching gnt.
REQ-008 raddr  input  NREQ x ADDR_W  per-requester register address; stable while req is high.
REQ-009 gnt  output  NREQ  one-hot, one-cycle grant pulse to the serviced requester.
REQ-010 mux_sel  output  ADDR_W  select driven to the shared 32x64 read mux.
REQ-011 mux_data  input  DATA_W  combinational data returned by the read mux.
REQ-012 rd_valid  output  1  rd_data/rd_id hold a valid result.
REQ-013 rd_ready  input  1  consumer accepts the result when rd_valid && rd_ready.
REQ-014 rd_id  output  clog2(NREQ)  index of the requester owning rd_data.
REQ-015 rd_data  output  DATA_W  registered read result.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, READ, WAIT.
REQ-017 IDLE: if any req is high, the FSM SHALL latch the round-robin winner's index and raddr and go to READ; otherwise it SHALL stay in IDLE.
REQ-018 Winner selection SHALL scan from ptr+1 upward, wrapping modulo NREQ, where ptr is the index of the last accepted result.
REQ-019 READ: mux_sel SHALL equal the latched address, gnt[winner] SHALL be 1 for this cycle only, rd_data SHALL capture mux_data at the cycle's end, rd_id SHALL capture the winner, and the FSM SHALL go to WAIT.
REQ-020 WAIT: rd_valid SHALL be 1, and rd_data and rd_id SHALL be held stable until accepted.
REQ-021 WAIT with rd_ready=1: ptr SHALL update to rd_id; if any req is high, the new winner (using the updated ptr) SHALL be latched and the FSM SHALL go to READ; otherwise it SHALL go to IDLE.
REQ-022 WAIT with rd_ready=0: the FSM SHALL stay in WAIT and issue no grants.
REQ-023 Latency SHALL be gnt one cycle after selection, rd_valid one cycle after gnt, and a sustained throughput of one result per two cycles.
REQ-024 gnt SHALL be all-zero outside READ, and mux_sel SHALL hold its last value outside READ.
REQ-025 A req deasserted before gnt SHALL not be serviced unless it has already been latched; a latched request SHALL always complete.
REQ-026 The same requester SHALL not be granted twice in a row while any other req is pending.

Reset
REQ-027 On reset the block SHALL set state to IDLE, gnt=0, rd_valid=0, rd_id=0, rd_data=0, mux_sel=0 and ptr=NREQ-1, so that requester 0 has first priority.
REQ-028 Reset asserted in READ or WAIT SHALL discard the in-flight result without producing a gnt or rd_valid in the reset cycle.

Configuration
REQ-029 With RF_XZR_EN defined, a latched address of 31 SHALL load rd_data=0 regardless of mux_data, while gnt and timing stay unchanged.
REQ-030 Without RF_XZR_EN, address 31 SHALL return mux_data like any other register.

Structure
REQ-031 Package rf_arb_pkg SHALL hold the NREQ, ADDR_W and DATA_W defaults, the ID_W constant, and the state enum typedef (IDLE, READ, WAIT).
REQ-032 One combinational sub-module, rr_picker, SHALL take req and ptr and return a found flag and winner index; all state SHALL remain in rf_read_arbiter.

Verification
REQ-033 After reset, req=4'b0001 with raddr[0]=3 and mux model data=reg index*0x1111 SHALL give gnt=0001 one cycle later, then rd_valid=1, rd_id=0 and rd_data=0x3333.
REQ-034 req=4'b1111 held with rd_ready=1 SHALL produce grant order 0,1,2,3,0, with a gnt every second cycle.
REQ-035 rd_ready=0 for 5 cycles with req=4'b0110 SHALL hold rd_valid=1 with rd_data unchanged and no gnt; on rd_ready=1 the next gnt SHALL go to the other pending requester.
REQ-036 Reset pulsed in the WAIT cycle SHALL give rd_valid=0 the next cycle, and a subsequent req=4'b1000 SHALL be granted to requester 3.
REQ-037 raddr=31 with mux_data=0xDEAD SHALL return rd_data=0 with RF_XZR_EN defined and rd_data=0xDEAD without it.
REQ-038 Every cycle the bench SHALL check that gnt is one-hot or zero and that each gnt maps to exactly one rd_valid handshake.
